// File: rtl/onn_pkg.sv
// Shared types for the oscillatory neural network coupling logic.
// Holds the FSM state enum, default weight width and weight typedef.
package onn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } onn_state_t;

  localparam int W_WIDTH_DEF = 5;

  typedef logic signed [W_WIDTH_DEF-1:0] coupling_weight_t;

endpackage

// File: rtl/onn_weight_bank.sv
// Coupling weight register file with serial load index.
// Ports: clk, reset, restart, wr_en, w_data -> weights (flat), last_write.
module onn_weight_bank
  import onn_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = W_WIDTH_DEF,
  localparam int IDX_W  = $clog2(N_IN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      restart,
  input  logic                      wr_en,
  input  logic [W_WIDTH-1:0]        w_data,
  output logic [N_IN*W_WIDTH-1:0]   weights,
  output logic                      last_write
);

  logic [IDX_W-1:0]   idx;
  logic [W_WIDTH-1:0] bank [N_IN];

  assign last_write = wr_en && (idx == IDX_W'(N_IN - 1));

  for (genvar i = 0; i < N_IN; i++) begin : g_flat
    assign weights[i*W_WIDTH +: W_WIDTH] = bank[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      for (int i = 0; i < N_IN; i++) begin
        bank[i] <= '0;
      end
    end else if (restart) begin
      idx <= '0;
    end else if (wr_en) begin
      bank[idx] <= w_data;
      idx       <= last_write ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/onn_coupling_sum.sv
// Weighted coupling sum of neighbour oscillators with hysteretic threshold.
// Ports: clk, reset, load_start, w_valid/w_data/w_ready, osc_in -> weights_loaded, sum_out, nin_out.
module onn_coupling_sum
  import onn_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = W_WIDTH_DEF,
  localparam int SUM_W  = W_WIDTH + 1 + $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    w_valid,
  input  logic [W_WIDTH-1:0]      w_data,
  output logic                    w_ready,
  input  logic [N_IN-1:0]         osc_in,
  output logic                    weights_loaded,
  output logic signed [SUM_W-1:0] sum_out,
  output logic                    nin_out
);

  onn_state_t                  state;
  logic [N_IN*W_WIDTH-1:0]     weights;
  logic                        last_write;
  logic                        wr_en;
  logic [N_IN-1:0]             osc_q;
  logic                        osc_v;
  logic                        sum_v;
  logic signed [SUM_W-1:0]     term [N_IN];
  logic signed [SUM_W-1:0]     sum_d;

  assign w_ready = (state == LOAD);
  // restart wins over a simultaneous word
  assign wr_en   = w_valid && w_ready && !load_start;

  onn_weight_bank #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .restart    (load_start),
    .wr_en      (wr_en),
    .w_data     (w_data),
    .weights    (weights),
    .last_write (last_write)
  );

  // extend before negating so the most negative weight flips exactly
  for (genvar i = 0; i < N_IN; i++) begin : g_term
    logic signed [W_WIDTH-1:0] w_i;
    assign w_i     = weights[i*W_WIDTH +: W_WIDTH];
    assign term[i] = osc_q[i] ? SUM_W'(w_i) : -SUM_W'(w_i);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum_d = sum_d + term[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      weights_loaded <= 1'b0;
      osc_q          <= '0;
      osc_v          <= 1'b0;
      sum_v          <= 1'b0;
      sum_out        <= '0;
      nin_out        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) state <= LOAD;
        end
        LOAD: begin
          if (last_write) begin
            state          <= RUN;
            weights_loaded <= 1'b1;
          end
        end
        RUN: begin
          if (load_start) begin
            state          <= LOAD;
            weights_loaded <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // stage valids keep stale data out of sum_out/nin_out on RUN entry
      if (state == RUN) begin
        osc_q <= osc_in;
        osc_v <= 1'b1;
        if (osc_v) begin
          sum_out <= sum_d;
          sum_v   <= 1'b1;
        end
        if (sum_v) begin
          if (sum_out > 0)      nin_out <= 1'b1;
          else if (sum_out < 0) nin_out <= 1'b0;
        end
      end else begin
        osc_v <= 1'b0;
        sum_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onn_coupling_sum.sv
// Self-checking bench for onn_coupling_sum.
// Table of vectors plus restart/reset sequences, scoreboard queues.
module tb_onn_coupling_sum;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic              w_valid;
  logic [4:0]        w_data;
  logic              w_ready;
  logic [3:0]        osc_in;
  logic              weights_loaded;
  logic signed [7:0] sum_out;
  logic              nin_out;

  onn_coupling_sum dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .w_valid        (w_valid),
    .w_data         (w_data),
    .w_ready        (w_ready),
    .osc_in         (osc_in),
    .weights_loaded (weights_loaded),
    .sum_out        (sum_out),
    .nin_out        (nin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  typedef struct {
    int         set;
    logic [3:0] osc;
    int         sum;
    int         nin;
    int         hold;
  } vec_t;

  exp_t sum_q[$];
  exp_t nin_q[$];
  vec_t tbl[$];
  logic signed [4:0] wset [3][4];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sum_q.size() > 0 && sum_q[0].due <= cyc) begin
      e = sum_q.pop_front();
      if (e.due == cyc) chk("sum_out", int'(sum_out), e.val);
      else chk("sum_due", cyc, e.due);
    end
    if (nin_q.size() > 0 && nin_q[0].due <= cyc) begin
      e = nin_q.pop_front();
      if (e.due == cyc) chk("nin_out", int'(nin_out), e.val);
      else chk("nin_due", cyc, e.due);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] osc, input int s, input int n, input int hold);
    osc_in = osc;
    sum_q.push_back('{due: cyc + 2, val: s});
    nin_q.push_back('{due: cyc + 3, val: n});
    repeat (hold) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sum_q.size() == 0 && nin_q.size() == 0) break;
      step();
    end
    chk("drain", sum_q.size() + nin_q.size(), 0);
    sum_q.delete();
    nin_q.delete();
  endtask

  task automatic load_set(input int s);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("w_ready_load", int'(w_ready), 1);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_data  = wset[s][i];
      step();
    end
    w_valid = 1'b0;
    chk("weights_loaded", int'(weights_loaded), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cur;
    wset[0] = '{5'sd3, -5'sd2, 5'sd5, 5'sd1};
    wset[1] = '{5'sd4, 5'sd4, 5'sd0, 5'sd0};
    wset[2] = '{-5'sd16, -5'sd16, -5'sd16, -5'sd16};

    tbl.push_back('{0, 4'b0101,   9, 1, 4});
    tbl.push_back('{0, 4'b1010,  -9, 0, 4});
    tbl.push_back('{0, 4'b0011,  -5, 0, 4});
    tbl.push_back('{0, 4'b0101,   9, 1, 1});
    tbl.push_back('{0, 4'b1010,  -9, 0, 1});
    tbl.push_back('{0, 4'b0011,  -5, 0, 1});
    tbl.push_back('{0, 4'b0101,   9, 1, 4});
    tbl.push_back('{1, 4'b0011,   8, 1, 4});
    tbl.push_back('{1, 4'b0001,   0, 1, 4});
    tbl.push_back('{2, 4'b0000,  64, 1, 4});
    tbl.push_back('{2, 4'b1111, -64, 0, 4});

    reset      = 1'b1;
    load_start = 1'b0;
    w_valid    = 1'b0;
    w_data     = '0;
    osc_in     = '0;
    repeat (3) step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_sum", int'(sum_out), 0);
      chk("idle_nin", int'(nin_out), 0);
      chk("idle_w_ready", int'(w_ready), 0);
      chk("idle_loaded", int'(weights_loaded), 0);
    end

    cur = -1;
    foreach (tbl[i]) begin
      if (tbl[i].set != cur) begin
        drain();
        cur = tbl[i].set;
        load_set(cur);
      end
      drive(tbl[i].osc, tbl[i].sum, tbl[i].nin, tbl[i].hold);
    end
    drain();

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    w_valid = 1'b1;
    w_data  = 5'd7;
    step();
    step();
    load_start = 1'b1;
    w_data     = 5'b10000;
    step();
    load_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      w_data = 5'(i);
      step();
    end
    chk("restart_not_loaded", int'(weights_loaded), 0);
    w_data = 5'd4;
    step();
    w_valid = 1'b0;
    chk("restart_loaded", int'(weights_loaded), 1);
    drive(4'b1111, 10, 1, 4);
    drain();

    w_valid = 1'b1;
    w_data  = 5'b10000;
    chk("run_w_ready", int'(w_ready), 0);
    step();
    step();
    w_valid = 1'b0;
    drive(4'b0000, -10, 0, 4);
    drain();

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    w_valid = 1'b1;
    w_data  = 5'd9;
    step();
    step();
    w_valid = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_nin", int'(nin_out), 0);
    chk("rst_w_ready", int'(w_ready), 0);
    chk("rst_loaded", int'(weights_loaded), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/onn_coupling_sum.md
# onn_coupling_sum

Coupling stage that feeds a neuron's `nin` input in the oscillatory neural network. It samples the square-wave outputs (`nout`) of `N_IN` neighbouring neurons and multiplies each by a signed coupling weight. A neighbour at logic 1 contributes +w, and a neighbour at logic 0 contributes −w. The weighted sum is thresholded into a single binary drive signal for the downstream neuron. Weights are loaded serially through a valid/ready handshake before the network runs.

## Interface
- `N_IN`, 4: number of neighbour oscillator inputs (≥2).
- `W_WIDTH`, 5: signed coupling weight width, two's complement.
- `SUM_W`, `W_WIDTH+1+$clog2(N_IN)`: derived internal constant, not overridable.

- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `load_start` input 1: single-cycle pulse that begins (or restarts) weight loading.
- `w_valid` input 1: weight word present on `w_data`.
- `w_data` input `W_WIDTH`: signed weight; words arrive in index order 0..N_IN−1.
- `w_ready` output 1: accepting weights; high only in LOAD.
- `osc_in` input `N_IN`: neighbour `nout` signals, synchronous to `clk`.
- `weights_loaded` output 1: all N_IN weights are written and the block is in RUN.
- `sum_out` output `SUM_W`: signed weighted sum, registered.
- `nin_out` output 1: thresholded drive to the neuron's `nin`.

## Operation
- FSM states:
  - IDLE (reset state).
  - LOAD.
  - RUN.
- IDLE:
  - `load_start` → LOAD.
  - `sum_out` = 0 and `nin_out` = 0; the datapath is frozen.
- LOAD:
  - The weight index starts at 0.
  - Each cycle with `w_valid && w_ready` writes `weight[idx] <= w_data` and increments idx.
  - The write of index N_IN−1 moves the FSM to RUN on the same edge.
  - `load_start` in LOAD resets idx to 0. Any `w_valid` in that cycle is discarded, because restart has priority. Previously written weights stay until overwritten.
  - `sum_out` and `nin_out` hold their last values.
- RUN:
  - Pipeline runs every cycle.
  - `load_start` → LOAD: `weights_loaded` drops and the index restarts at 0.
- `w_valid` outside LOAD is ignored, and no weight changes.
- Arithmetic:
  - Each term is ±`weight[i]`, sign-extended to SUM_W before negation, so −(−2^(W_WIDTH−1)) is exact.
  - The sum of N_IN terms never overflows SUM_W.
- Threshold (hysteretic):
  - `sum_out` > 0 → `nin_out` = 1.
  - `sum_out` < 0 → `nin_out` = 0.
  - `sum_out` = 0 → `nin_out` holds its previous value.
- Reset in any state:
  - FSM → IDLE, all weights = 0, idx = 0.
  - `sum_out` = 0, `nin_out` = 0, `w_ready` = 0, `weights_loaded` = 0.

## Timing
- Pipeline in RUN:
  - Edge 1: register `osc_in` into `osc_q`.
  - Edge 2: register the sum from `osc_q` into `sum_out`.
  - Edge 3: register the threshold of `sum_out` into `nin_out`.
- Latency: `osc_in` change at edge t appears on `sum_out` after edge t+2 and on `nin_out` after edge t+3.
- Throughput: one new sample per cycle.
- The pipeline begins sampling on the first RUN cycle:
  - The first valid `sum_out` is 2 cycles after `weights_loaded` rises.
  - Until then, `sum_out` keeps its prior value (0 after reset).
- `w_ready` is combinational from state (= LOAD), so it rises the cycle after `load_start`.
- `weights_loaded` is registered and rises the edge after the last weight write.

## Structure
- Shared package `onn_pkg` holds:
  - the FSM state enum (IDLE/LOAD/RUN);
  - the default `W_WIDTH` constant;
  - a `coupling_weight_t` signed typedef.
- One sub-module, `onn_weight_bank`, holds the N_IN×W_WIDTH register file, the load index and the last-write detection.
- The FSM, sum pipeline and threshold stay in the top module.

## Test plan
- Reset, then idle 10 cycles → `sum_out`=0, `nin_out`=0, `w_ready`=0, `weights_loaded`=0 throughout.
- Load weights {3, −2, 5, 1} with back-to-back `w_valid`, then `osc_in`=4'b0101 → after 2 cycles `sum_out` = +3+2+5−1 = 9; after 3 cycles `nin_out` = 1.
- Same weights, `osc_in`=4'b1010 → `sum_out` = −9, `nin_out` = 0. Then `osc_in`=4'b0011 → `sum_out` = 3−2−5−1 = −5, `nin_out` stays 0.
- Zero-sum hold: weights {4, 4, 0, 0}, `osc_in` 4'b0011 then 4'b0001 → `sum_out` 8 then 0, `nin_out` stays 1.
- All weights −16, `osc_in`=4'b0000 → `sum_out` = +64 with no overflow. `osc_in`=4'b1111 → `sum_out` = −64.
- Boundary cases:
  - `load_start` after 2 of 4 words, with `w_valid` asserted in the same cycle → that word is dropped, idx restarts and 4 more words are needed before `weights_loaded`.
  - `reset` asserted mid-LOAD → all outputs and weights return to 0 the next cycle.
